// File: rtl/mul_scheduler.sv
// mul_scheduler: shares one variable-latency multiplier between two requesters.
// Round-robin arbitration, one operation in flight, tagged responses, optional
// constant-time padding so timing does not reveal the multiplier's zero fast path.
module mul_scheduler #(
  parameter int WIDTH       = 4,
  parameter int MUL_LATENCY = 3,
  parameter int TIMEOUT     = 7
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ct_mode,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [WIDTH-1:0]   i_req0_a,
  input  logic [WIDTH-1:0]   i_req0_b,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [WIDTH-1:0]   i_req1_a,
  input  logic [WIDTH-1:0]   i_req1_b,
  output logic               o_mul_start,
  output logic [WIDTH-1:0]   o_mul_a,
  output logic [WIDTH-1:0]   o_mul_b,
  input  logic               i_mul_done,
  input  logic [2*WIDTH-1:0] i_mul_result,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic               o_resp_id,
  output logic [2*WIDTH-1:0] o_resp_result,
  output logic               o_resp_err,
  output logic               o_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_rr;
  logic               r_id;
  logic               r_ct;
  logic               r_done_seen;
  logic               r_err;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_result;
  logic [CW-1:0]      r_cnt;

  logic               w_grant;
  logic               w_accept;
  logic               w_have_done;
  logic               w_timeout;
  logic               w_done_exit;

  // Arbitration and WAIT-exit conditions; the constant-time exit waits one cycle
  // past the worst-case done so the exit edge never depends on when done arrived.
  always_comb begin
    w_grant     = (i_req0_valid && i_req1_valid) ? r_rr : i_req1_valid;
    w_accept    = (r_state == S_IDLE) && (i_req0_valid || i_req1_valid);
    w_have_done = r_done_seen || i_mul_done;
    w_timeout   = (r_cnt == CW'(TIMEOUT)) && !w_have_done;
    w_done_exit = r_ct ? (w_have_done && (r_cnt > CW'(MUL_LATENCY))) : i_mul_done;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next_state  = r_state;
    o_req0_ready  = 1'b0;
    o_req1_ready  = 1'b0;
    o_mul_start   = 1'b0;
    o_mul_a       = '0;
    o_mul_b       = '0;
    o_resp_valid  = 1'b0;
    o_resp_id     = 1'b0;
    o_resp_result = '0;
    o_resp_err    = 1'b0;
    o_busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        o_req0_ready = i_req0_valid && !w_grant;
        o_req1_ready = i_req1_valid && w_grant;
        if (w_accept) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        o_mul_start  = 1'b1;
        o_mul_a      = r_a;
        o_mul_b      = r_b;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        o_mul_a = r_a;
        o_mul_b = r_b;
        if (w_done_exit || w_timeout) w_next_state = S_RESP;
      end
      S_RESP: begin
        o_resp_valid  = 1'b1;
        o_resp_id     = r_id;
        o_resp_result = r_result;
        o_resp_err    = r_err;
        if (i_resp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand latch, WAIT counter, first-done capture, timeout and RR pointer update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr        <= 1'b0;
      r_id        <= 1'b0;
      r_ct        <= 1'b0;
      r_done_seen <= 1'b0;
      r_err       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= w_grant ? i_req1_a : i_req0_a;
            r_b      <= w_grant ? i_req1_b : i_req0_b;
            r_id     <= w_grant;
            r_ct     <= i_ct_mode;
            r_result <= '0;
            r_err    <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_cnt       <= CW'(1);
          r_done_seen <= 1'b0;
        end
        S_WAIT: begin
          if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
          if (i_mul_done && !r_done_seen) begin
            r_result    <= i_mul_result;
            r_done_seen <= 1'b1;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_rr  <= ~r_id;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Testbench for mul_scheduler: directed operations against a timing/arbitration
// model derived from the latency rules, plus literal expectations per scenario.
module tb_mul_scheduler;

  localparam int WIDTH       = 4;
  localparam int MUL_LATENCY = 3;
  localparam int TIMEOUT     = 7;

  logic       clock = 1'b0;
  logic       resetN;
  logic       ctMode;
  logic       req0Valid, req1Valid;
  logic [3:0] req0A, req0B, req1A, req1B;
  logic       req0Ready, req1Ready;
  logic       mulStart;
  logic [3:0] mulA, mulB;
  logic       mulDone;
  logic       emuDone, strayDone;
  logic [7:0] emuResult;
  logic       respValid, respReady, respId, respErr, busy;
  logic [7:0] respResult;

  int errors = 0;
  int checks = 0;
  int edgeCnt = 0;
  int mulDelay = 0;

  // model state, written only by the compare process
  logic       mBusy = 1'b0;
  logic       mRr = 1'b0;
  logic       mId = 1'b0;
  logic [3:0] mA = '0, mB = '0;
  logic [7:0] mRes = '0;
  logic       mErr = 1'b0;
  int         mAccEdge = 0;
  int         mLat = 0;

  assign mulDone = emuDone | strayDone;

  mul_scheduler #(.WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clock),
    .i_rst_n      (resetN),
    .i_ct_mode    (ctMode),
    .i_req0_valid (req0Valid),
    .o_req0_ready (req0Ready),
    .i_req0_a     (req0A),
    .i_req0_b     (req0B),
    .i_req1_valid (req1Valid),
    .o_req1_ready (req1Ready),
    .i_req1_a     (req1A),
    .i_req1_b     (req1B),
    .o_mul_start  (mulStart),
    .o_mul_a      (mulA),
    .o_mul_b      (mulB),
    .i_mul_done   (mulDone),
    .i_mul_result (emuResult),
    .o_resp_valid (respValid),
    .i_resp_ready (respReady),
    .o_resp_id    (respId),
    .o_resp_result(respResult),
    .o_resp_err   (respErr),
    .o_busy       (busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Edge counter used to measure latency in clock edges.
  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Multiplier stand-in: after mul_start, pulses done in WAIT cycle mulDelay (0 = never).
  initial begin : mulEmu
    logic [3:0] pa, pb;
    int d;
    emuDone = 1'b0;
    emuResult = '0;
    forever begin
      @(negedge clock);
      if (mulStart && mulDelay > 0) begin
        pa = mulA;
        pb = mulB;
        d = mulDelay;
        repeat (d) @(posedge clock);
        #1;
        emuDone = 1'b1;
        emuResult = {4'b0, pa} * {4'b0, pb};
        @(posedge clock);
        #1 emuDone = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the behavioural model.
  initial begin : compareProc
    logic expValid, expR0, expR1;
    int d;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        mBusy = 1'b0;
        mRr = 1'b0;
      end
      expValid = mBusy && ((edgeCnt - mAccEdge) >= mLat);
      expR0 = !mBusy && req0Valid && !(req1Valid && mRr);
      expR1 = !mBusy && req1Valid && !(req0Valid && !mRr);
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("req0_ready", 32'(req0Ready), 32'(expR0));
      checkOutput("req1_ready", 32'(req1Ready), 32'(expR1));
      checkOutput("mul_start", 32'(mulStart), 32'(mBusy && (edgeCnt == mAccEdge)));
      checkOutput("resp_valid", 32'(respValid), 32'(expValid));
      if (!mBusy || !expValid) begin
        checkOutput("mul_a", 32'(mulA), mBusy ? 32'(mA) : 32'd0);
        checkOutput("mul_b", 32'(mulB), mBusy ? 32'(mB) : 32'd0);
      end
      if (expValid) begin
        checkOutput("resp_id", 32'(respId), 32'(mId));
        checkOutput("resp_result", 32'(respResult), 32'(mRes));
        checkOutput("resp_err", 32'(respErr), 32'(mErr));
      end
      if (resetN) begin
        if (expValid && respReady) begin
          mBusy = 1'b0;
          mRr = !mId;
        end else if (expR0 || expR1) begin
          mBusy = 1'b1;
          mAccEdge = edgeCnt + 1;
          mId = expR1;
          mA = expR1 ? req1A : req0A;
          mB = expR1 ? req1B : req0B;
          d = mulDelay;
          if (d >= 1 && d <= TIMEOUT) begin
            mErr = 1'b0;
            mRes = {4'b0, mA} * {4'b0, mB};
            if (ctMode) mLat = 1 + ((d > MUL_LATENCY) ? d : MUL_LATENCY + 1);
            else mLat = 1 + d;
          end else begin
            mErr = 1'b1;
            mRes = '0;
            mLat = 1 + TIMEOUT;
          end
        end
      end
    end
  end

  // One operation from one requester: accept, wait for response, backpressure, handshake.
  task automatic applyStimulus(input logic sel, input logic [3:0] a, input logic [3:0] b,
                               input logic ct, input int delay, input int hold,
                               output int lat, output logic rid, output logic [7:0] rres,
                               output logic rerr, output int starts);
    int n;
    int accEdge;
    logic ok;
    lat = -1; rid = 1'b0; rres = '0; rerr = 1'b0; starts = 0;
    mulDelay = delay;
    @(posedge clock);
    #1;
    ctMode = ct;
    if (sel) begin req1Valid = 1'b1; req1A = a; req1B = b; end
    else begin req0Valid = 1'b1; req0A = a; req0B = b; end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(sel ? req1Ready : req0Ready) && n < 20);
    ok = sel ? req1Ready : req0Ready;
    checkOutput("accept_seen", 32'(ok), 32'd1);
    @(posedge clock);
    #1;
    accEdge = edgeCnt;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    ctMode = 1'b0;
    if (!ok) return;
    n = 0;
    do begin
      @(negedge clock);
      if (mulStart) starts++;
      n++;
    end while (!respValid && n < 40);
    checkOutput("resp_seen", 32'(respValid), 32'd1);
    if (!respValid) return;
    lat = edgeCnt - accEdge;
    rid = respId;
    rres = respResult;
    rerr = respErr;
    repeat (hold + 1) @(posedge clock);
    #1 respReady = 1'b1;
    @(posedge clock);
    #1 respReady = 1'b0;
  endtask

  // Directed scenarios.
  initial begin : mainProc
    int lat, starts, n;
    logic rid, rerr, seen, gotReady;
    logic [7:0] rres;
    logic [3:0] grants;

    resetN = 1'b0; ctMode = 1'b0; respReady = 1'b0; strayDone = 1'b0;
    req0Valid = 1'b0; req1Valid = 1'b0;
    req0A = '0; req0B = '0; req1A = '0; req1B = '0;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;

    // reset mid-WAIT drops the operation; a late done is ignored
    $display("[TB] reset during WAIT");
    mulDelay = 0;
    @(posedge clock);
    #1 req0Valid = 1'b1; req0A = 4'd6; req0B = 4'd2;
    n = 0;
    do begin @(negedge clock); n++; end while (!req0Ready && n < 20);
    checkOutput("reset_accept", 32'(req0Ready), 32'd1);
    @(posedge clock);
    #1 req0Valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b0;
    @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_resp_valid", 32'(respValid), 32'd0);
    checkOutput("reset_mul_start", 32'(mulStart), 32'd0);
    checkOutput("reset_mul_a", 32'(mulA), 32'd0);
    checkOutput("reset_resp_result", 32'(respResult), 32'd0);
    checkOutput("reset_resp_err", 32'(respErr), 32'd0);
    @(posedge clock);
    #1 resetN = 1'b1;
    @(posedge clock);
    #1 strayDone = 1'b1;
    @(posedge clock);
    #1 strayDone = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (respValid || busy) seen = 1'b1;
    end
    checkOutput("reset_stray_done", 32'(seen), 32'd0);

    // single op, normal mode, done in third WAIT cycle
    $display("[TB] single op");
    applyStimulus(1'b0, 4'd3, 4'd5, 1'b0, 3, 0, lat, rid, rres, rerr, starts);
    checkOutput("single_lat", 32'(lat), 32'd4);
    checkOutput("single_id", 32'(rid), 32'd0);
    checkOutput("single_result", 32'(rres), 32'd15);
    checkOutput("single_err", 32'(rerr), 32'd0);
    checkOutput("single_starts", 32'(starts), 32'd1);

    // constant-time: zero fast path and slow path give the same latency
    $display("[TB] constant time");
    applyStimulus(1'b1, 4'd0, 4'd7, 1'b1, 1, 0, lat, rid, rres, rerr, starts);
    checkOutput("ct_fast_lat", 32'(lat), 32'd5);
    checkOutput("ct_fast_id", 32'(rid), 32'd1);
    checkOutput("ct_fast_result", 32'(rres), 32'd0);
    applyStimulus(1'b1, 4'd2, 4'd7, 1'b1, 3, 0, lat, rid, rres, rerr, starts);
    checkOutput("ct_slow_lat", 32'(lat), 32'd5);
    checkOutput("ct_slow_result", 32'(rres), 32'd14);

    // minimum latency and full-width product
    $display("[TB] minimum latency");
    applyStimulus(1'b0, 4'd15, 4'd15, 1'b0, 1, 0, lat, rid, rres, rerr, starts);
    checkOutput("min_lat", 32'(lat), 32'd2);
    checkOutput("min_result", 32'(rres), 32'd225);

    // backpressure: response held for several cycles
    $display("[TB] backpressure");
    applyStimulus(1'b0, 4'd9, 4'd9, 1'b0, 2, 4, lat, rid, rres, rerr, starts);
    checkOutput("bp_lat", 32'(lat), 32'd3);
    checkOutput("bp_result", 32'(rres), 32'd81);

    // timeouts, and done landing on the timeout cycle
    $display("[TB] timeout");
    applyStimulus(1'b1, 4'd5, 4'd3, 1'b0, 0, 0, lat, rid, rres, rerr, starts);
    checkOutput("to_lat", 32'(lat), 32'd8);
    checkOutput("to_err", 32'(rerr), 32'd1);
    checkOutput("to_result", 32'(rres), 32'd0);
    applyStimulus(1'b0, 4'd5, 4'd3, 1'b0, 7, 0, lat, rid, rres, rerr, starts);
    checkOutput("to_race_lat", 32'(lat), 32'd8);
    checkOutput("to_race_err", 32'(rerr), 32'd0);
    checkOutput("to_race_result", 32'(rres), 32'd15);
    applyStimulus(1'b1, 4'd4, 4'd4, 1'b1, 0, 0, lat, rid, rres, rerr, starts);
    checkOutput("to_ct_lat", 32'(lat), 32'd8);
    checkOutput("to_ct_err", 32'(rerr), 32'd1);

    // contention after reset: grants alternate, first response backpressured
    $display("[TB] contention");
    @(posedge clock);
    #1 resetN = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    mulDelay = 2;
    req0A = 4'd4; req0B = 4'd6; req1A = 4'd9; req1B = 4'd3;
    req0Valid = 1'b1; req1Valid = 1'b1;
    grants = '0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!(req0Ready || req1Ready) && n < 20);
      gotReady = req0Ready || req1Ready;
      checkOutput("cont_accept", 32'(gotReady), 32'd1);
      grants[k] = req1Ready;
      n = 0;
      do begin @(negedge clock); n++; end while (!respValid && n < 40);
      checkOutput("cont_resp_seen", 32'(respValid), 32'd1);
      repeat ((k == 0) ? 5 : 1) @(posedge clock);
      #1 respReady = 1'b1;
      @(posedge clock);
      #1 respReady = 1'b0;
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    checkOutput("cont_grants", 32'(grants), 32'b1010);
    repeat (3) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
